// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: ALU opcodes, MIPS op/funct codes and
// the issue entry carried through the skid buffer.
package alu_pkg;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_U_ADD = 4'b1000;
    localparam logic [3:0] ALU_U_SUB = 4'b1001;
    localparam logic [3:0] ALU_S_ADD = 4'b1100;
    localparam logic [3:0] ALU_S_SUB = 4'b1101;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;

    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  opcode;
        logic        illegal;
    } issue_entry_t;

    localparam issue_entry_t ENTRY_RESET = '{a: 32'h0000_0000, b: 32'h0000_0000,
                                             opcode: 4'b0000, illegal: 1'b0};

    function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_skid_buf.sv
// Two-entry valid/ready skid buffer for issue entries. The main slot drives the
// outputs; in_ready depends only on registered skid occupancy.
module alu_skid_buf
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  issue_entry_t in_entry,
    output logic         out_valid,
    input  logic         out_ready,
    output issue_entry_t out_entry
);

    logic         main_valid_r;
    issue_entry_t main_r;
    logic         skid_full_r;
    issue_entry_t skid_r;
    logic         accept_s;
    logic         emit_s;

    assign accept_s  = in_valid & ~skid_full_r;
    assign emit_s    = main_valid_r & out_ready;
    assign in_ready  = ~skid_full_r;
    assign out_valid = main_valid_r;
    assign out_entry = main_r;

    // Slot movement: skid refills main first, otherwise new entries land in main
    // when it frees up this cycle and spill to the skid slot when it does not.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_r <= 1'b0;
            main_r       <= ENTRY_RESET;
            skid_full_r  <= 1'b0;
            skid_r       <= ENTRY_RESET;
        end else if (emit_s && skid_full_r) begin
            main_r      <= skid_r;
            skid_full_r <= 1'b0;
        end else if (accept_s && (!main_valid_r || emit_s)) begin
            main_r       <= in_entry;
            main_valid_r <= 1'b1;
        end else if (accept_s) begin
            skid_r      <= in_entry;
            skid_full_r <= 1'b1;
        end else if (emit_s) begin
            main_valid_r <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes MIPS arithmetic instructions into ALU opcode/operands and
// hands them to a skid buffer. Define ALU_ISSUE_FWD_EN to add operand forwarding ports.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
`ifdef ALU_ISSUE_FWD_EN
    input  logic              fwd_valid,
    input  logic [REG_AW-1:0] fwd_reg,
    input  logic [31:0]       fwd_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [3:0]        out_opcode,
    output logic              out_illegal
);

    logic [5:0]        op_s;
    logic [5:0]        funct_s;
    logic [15:0]       imm_s;
    logic [3:0]        opcode_s;
    logic              illegal_s;
    logic              use_imm_s;
    logic              rtype_s;
    logic [31:0]       a_s;
    logic [31:0]       b_s;
    issue_entry_t      entry_s;
    issue_entry_t      held_s;

    assign op_s    = in_instr[31:26];
    assign funct_s = in_instr[5:0];
    assign imm_s   = in_instr[15:0];

    // Opcode decode; unknown encodings become NOP flagged illegal.
    always_comb begin
        opcode_s  = ALU_NOP;
        illegal_s = 1'b1;
        use_imm_s = 1'b0;
        rtype_s   = 1'b0;
        case (op_s)
            OP_RTYPE: begin
                rtype_s = 1'b1;
                case (funct_s)
                    FN_ADD:  begin opcode_s = ALU_S_ADD; illegal_s = 1'b0; end
                    FN_SUB:  begin opcode_s = ALU_S_SUB; illegal_s = 1'b0; end
                    FN_ADDU: begin opcode_s = ALU_U_ADD; illegal_s = 1'b0; end
                    FN_SUBU: begin opcode_s = ALU_U_SUB; illegal_s = 1'b0; end
                    default: begin opcode_s = ALU_NOP;   illegal_s = 1'b1; end
                endcase
            end
            OP_ADDI: begin
                opcode_s  = ALU_S_ADD;
                illegal_s = 1'b0;
                use_imm_s = 1'b1;
            end
            OP_ADDIU: begin
                opcode_s  = ALU_U_ADD;
                illegal_s = 1'b0;
                use_imm_s = 1'b1;
            end
            default: begin
                opcode_s  = ALU_NOP;
                illegal_s = 1'b1;
            end
        endcase
    end

`ifdef ALU_ISSUE_FWD_EN
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic              fwd_live_s;
    logic              fwd_rs_hit_s;
    logic              fwd_rt_hit_s;

    assign rs_s         = in_instr[25:21];
    assign rt_s         = in_instr[20:16];
    assign fwd_live_s   = fwd_valid & (fwd_reg != {REG_AW{1'b0}});
    assign fwd_rs_hit_s = fwd_live_s & (fwd_reg == rs_s);
    // Only register-sourced B is forwarded; immediates come straight from the word.
    assign fwd_rt_hit_s = fwd_live_s & rtype_s & (fwd_reg == rt_s);
    assign a_s = fwd_rs_hit_s ? fwd_data : in_rs_val;
    assign b_s = use_imm_s ? sign_ext16(imm_s) : (fwd_rt_hit_s ? fwd_data : in_rt_val);
`else
    assign a_s = in_rs_val;
    assign b_s = use_imm_s ? sign_ext16(imm_s) : in_rt_val;
`endif

    assign entry_s.a       = a_s;
    assign entry_s.b       = b_s;
    assign entry_s.opcode  = opcode_s;
    assign entry_s.illegal = illegal_s;

    alu_skid_buf u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_entry  (entry_s),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_entry (held_s)
    );

    assign out_a       = held_s.a;
    assign out_b       = held_s.b;
    assign out_opcode  = held_s.opcode;
    assign out_illegal = held_s.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode vector table plus handshake/reset sequences.
// Forwarding checks are compiled in when ALU_ISSUE_FWD_EN is defined.
module tb_alu_issue_stage;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs_val;
        logic [31:0] rt_val;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [3:0]  exp_op;
        logic        exp_ill;
        logic        chk_b;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_opcode;
    logic        out_illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_reg;
    logic [31:0] fwd_data;
`endif

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs [10];

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
`ifdef ALU_ISSUE_FWD_EN
        .fwd_valid   (fwd_valid),
        .fwd_reg     (fwd_reg),
        .fwd_data    (fwd_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_opcode  (out_opcode),
        .out_illegal (out_illegal)
    );

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [5:0] funct);
        return {6'h00, rs, rt, 5'd0, 5'd0, funct};
    endfunction

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] rs_val,
                         input logic [31:0] rt_val);
        in_valid  = 1'b1;
        in_instr  = instr;
        in_rs_val = rs_val;
        in_rt_val = rt_val;
    endtask

    initial begin
        vecs[0] = '{mk_r(5'd5, 5'd7, 6'h21), 32'd5, 32'd7, 32'd5, 32'd7, 4'b1000, 1'b0, 1'b1};
        vecs[1] = '{mk_r(5'd1, 5'd2, 6'h20), 32'h8000_0000, 32'd1, 32'h8000_0000, 32'd1, 4'b1100, 1'b0, 1'b1};
        vecs[2] = '{mk_r(5'd3, 5'd4, 6'h22), 32'd50, 32'd20, 32'd50, 32'd20, 4'b1101, 1'b0, 1'b1};
        vecs[3] = '{mk_r(5'd6, 5'd8, 6'h23), 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 4'b1001, 1'b0, 1'b1};
        vecs[4] = '{mk_i(6'h08, 5'd2, 5'd3, 16'hFFFF), 32'd3, 32'h1234, 32'd3, 32'hFFFF_FFFF, 4'b1100, 1'b0, 1'b1};
        vecs[5] = '{mk_i(6'h09, 5'd2, 5'd3, 16'h7FFF), 32'd9, 32'h55, 32'd9, 32'h0000_7FFF, 4'b1000, 1'b0, 1'b1};
        vecs[6] = '{mk_i(6'h09, 5'd4, 5'd5, 16'h8000), 32'd1, 32'h66, 32'd1, 32'hFFFF_8000, 4'b1000, 1'b0, 1'b1};
        vecs[7] = '{mk_i(6'h23, 5'd4, 5'd5, 16'h0010), 32'hABCD, 32'h77, 32'hABCD, 32'h0, 4'b0000, 1'b1, 1'b0};
        vecs[8] = '{mk_r(5'd9, 5'd10, 6'h00), 32'h42, 32'h43, 32'h42, 32'h0, 4'b0000, 1'b1, 1'b0};
        vecs[9] = '{mk_i(6'h08, 5'd7, 5'd7, 16'h0001), 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 32'd1, 4'b1100, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = 32'h0; in_rs_val = 32'h0; in_rt_val = 32'h0;
`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b0; fwd_reg = 5'd0; fwd_data = 32'h0;
`endif
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_opcode", {28'd0, out_opcode}, 32'd0);
        chk("rst_illegal", {31'd0, out_illegal}, 32'd0);
        rst = 1'b0;

        // Decode table, back-to-back with out_ready held high
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].instr, vecs[i].rs_val, vecs[i].rt_val);
            step();
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_a", i), out_a, vecs[i].exp_a);
            if (vecs[i].chk_b) chk($sformatf("v%0d_b", i), out_b, vecs[i].exp_b);
            chk($sformatf("v%0d_op", i), {28'd0, out_opcode}, {28'd0, vecs[i].exp_op});
            chk($sformatf("v%0d_ill", i), {31'd0, out_illegal}, {31'd0, vecs[i].exp_ill});
            chk($sformatf("v%0d_rdy", i), {31'd0, in_ready}, 32'd1);
        end
        step();
        chk("drain_valid", {31'd0, out_valid}, 32'd0);

        // Backpressure: four SUBs with three stalled cycles
        out_ready = 1'b0;
        drive(mk_r(5'd1, 5'd2, 6'h22), 32'd101, 32'd1);
        step();
        chk("bp1_rdy", {31'd0, in_ready}, 32'd1);
        chk("bp1_a", out_a, 32'd101);
        drive(mk_r(5'd1, 5'd2, 6'h22), 32'd102, 32'd1);
        step();
        chk("bp2_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp2_a", out_a, 32'd101);
        drive(mk_r(5'd1, 5'd2, 6'h22), 32'd103, 32'd1);
        step();
        chk("bp3_rdy", {31'd0, in_ready}, 32'd0);
        chk("bp3_a", out_a, 32'd101);
        chk("bp3_op", {28'd0, out_opcode}, 32'd13);
        chk("bp3_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        step();
        chk("bp4_a", out_a, 32'd102);
        chk("bp4_rdy", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp5_a", out_a, 32'd103);
        drive(mk_r(5'd1, 5'd2, 6'h22), 32'd104, 32'd1);
        step();
        chk("bp6_a", out_a, 32'd104);
        chk("bp6_valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp7_valid", {31'd0, out_valid}, 32'd0);

        // Async reset with both slots occupied
        out_ready = 1'b0;
        drive(mk_r(5'd1, 5'd2, 6'h21), 32'd201, 32'd2);
        step();
        drive(mk_r(5'd1, 5'd2, 6'h21), 32'd202, 32'd2);
        step();
        in_valid = 1'b0;
        chk("full_rdy", {31'd0, in_ready}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_a", out_a, 32'd0);
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        step();
        chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        drive(mk_r(5'd5, 5'd7, 6'h21), 32'd5, 32'd7);
        step();
        in_valid = 1'b0;
        chk("post_rst_a", out_a, 32'd5);
        chk("post_rst_b", out_b, 32'd7);
        step();

`ifdef ALU_ISSUE_FWD_EN
        fwd_valid = 1'b1; fwd_reg = 5'd9; fwd_data = 32'hDEAD_BEEF;
        drive(mk_r(5'd9, 5'd4, 6'h21), 32'd1, 32'd2);
        step();
        chk("fwd_a", out_a, 32'hDEAD_BEEF);
        chk("fwd_b_nohit", out_b, 32'd2);
        drive(mk_r(5'd3, 5'd9, 6'h20), 32'd1, 32'd2);
        step();
        chk("fwd_b", out_b, 32'hDEAD_BEEF);
        chk("fwd_a_nohit", out_a, 32'd1);
        drive(mk_i(6'h08, 5'd3, 5'd9, 16'h0004), 32'd1, 32'd2);
        step();
        chk("fwd_imm", out_b, 32'd4);
        fwd_reg = 5'd0;
        drive(mk_r(5'd0, 5'd0, 6'h21), 32'd11, 32'd12);
        step();
        chk("fwd_r0_a", out_a, 32'd11);
        chk("fwd_r0_b", out_b, 32'd12);
        in_valid = 1'b0; fwd_valid = 1'b0;
        step();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
